m6809_bus_timer: RTL and testbench

- Memory-mapped 16-bit programmable interval timer for the 6809 SOC: a bus responder to the CPU's read/write cycles.
- Raises an active-low IRQ to the CPU on timeout.
- Sits on the CPU data bus beside RAM/ROM inside m6809_integration, selected by an address decoder.
- Provides atomic 16-bit counter reads and buffered 16-bit reload writes for the 8-bit CPU.

---
 rtl/m6809_bus_timer.sv | 189 ++++++++++++++++++
 tb/tb_m6809_bus_timer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m6809_bus_timer.sv
// m6809_bus_timer: 16-bit programmable interval timer responding to the 6809
// CPU bus. Provides an 8-bit prescaler, a reloadable down-counter with
// periodic/one-shot modes, an active-low IRQ, buffered 16-bit reload writes
// and atomic 16-bit counter reads through a COUNT_HI-triggered low-byte latch.
module m6809_bus_timer #(
  parameter logic [15:0] RESET_RELOAD   = 16'h0000,
  parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_cs,
  input  logic       bus_rw,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_ack,
  output logic       irq_b
);

  // Register map.
  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd2;
  localparam logic [2:0] ADDR_RELOAD_HI = 3'd3;
  localparam logic [2:0] ADDR_RELOAD_LO = 3'd4;
  localparam logic [2:0] ADDR_COUNT_HI  = 3'd5;
  localparam logic [2:0] ADDR_COUNT_LO  = 3'd6;

  // Architectural state.
  logic        ctrl_en;
  logic        ctrl_ie;
  logic        ctrl_oneshot;
  logic        tf;
  logic [7:0]  prescale;
  logic [15:0] reload;
  logic [15:0] count;
  logic [7:0]  reload_hi_buf;
  logic [7:0]  count_lo_latch;
  logic [7:0]  presc_cnt;

  // Next-state values.
  logic        ctrl_en_nxt;
  logic        ctrl_ie_nxt;
  logic        ctrl_oneshot_nxt;
  logic        tf_nxt;
  logic [7:0]  prescale_nxt;
  logic [15:0] reload_nxt;
  logic [15:0] count_nxt;
  logic [7:0]  reload_hi_buf_nxt;
  logic [7:0]  count_lo_latch_nxt;
  logic [7:0]  presc_cnt_nxt;
  logic [7:0]  bus_dout_nxt;
  logic        irq_b_nxt;

  // Decoded bus strobes and timer events.
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic        expire;
  logic [7:0]  read_data;

  assign wr_en  = bus_cs & ~bus_rw;
  assign rd_en  = bus_cs & bus_rw;
  assign tick   = ctrl_en & (presc_cnt == prescale);
  assign expire = tick & (count == 16'h0000);

  // Read data multiplexer, sampled into bus_dout on the access edge.
  always_comb begin
    read_data = 8'h00;
    case (bus_addr)
      ADDR_CTRL:      read_data = {5'b00000, ctrl_oneshot, ctrl_ie, ctrl_en};
      ADDR_STATUS:    read_data = {7'b0000000, tf};
      ADDR_PRESCALE:  read_data = prescale;
      ADDR_RELOAD_HI: read_data = reload[15:8];
      ADDR_RELOAD_LO: read_data = reload[7:0];
      ADDR_COUNT_HI:  read_data = count[15:8];
      ADDR_COUNT_LO:  read_data = count_lo_latch;
      default:        read_data = 8'h00;
    endcase
  end

  // Timer next state: prescaler and counter first, then bus writes override
  // so a CPU write wins over the same-cycle automatic update, except that an
  // expiry always sets tf even when STATUS is being cleared.
  always_comb begin
    ctrl_en_nxt        = ctrl_en;
    ctrl_ie_nxt        = ctrl_ie;
    ctrl_oneshot_nxt   = ctrl_oneshot;
    tf_nxt             = tf;
    prescale_nxt       = prescale;
    reload_nxt         = reload;
    count_nxt          = count;
    reload_hi_buf_nxt  = reload_hi_buf;
    count_lo_latch_nxt = count_lo_latch;
    presc_cnt_nxt      = presc_cnt;
    bus_dout_nxt       = bus_dout;

    if (!ctrl_en || tick) begin
      presc_cnt_nxt = 8'h00;
    end else begin
      presc_cnt_nxt = presc_cnt + 8'd1;
    end

    if (tick) begin
      if (count != 16'h0000) begin
        count_nxt = count - 16'd1;
      end else if (ctrl_oneshot) begin
        ctrl_en_nxt = 1'b0;
      end else begin
        count_nxt = reload;
      end
    end

    if (wr_en) begin
      case (bus_addr)
        ADDR_CTRL: begin
          ctrl_en_nxt      = bus_din[0];
          ctrl_ie_nxt      = bus_din[1];
          ctrl_oneshot_nxt = bus_din[2];
        end
        ADDR_STATUS: begin
          if (bus_din[0]) begin
            tf_nxt = 1'b0;
          end
        end
        ADDR_PRESCALE: begin
          prescale_nxt  = bus_din;
          presc_cnt_nxt = 8'h00;
        end
        ADDR_RELOAD_HI: begin
          reload_hi_buf_nxt = bus_din;
        end
        ADDR_RELOAD_LO: begin
          reload_nxt = {reload_hi_buf, bus_din};
          count_nxt  = {reload_hi_buf, bus_din};
        end
        default: begin
        end
      endcase
    end

    if (expire) begin
      tf_nxt = 1'b1;
    end

    if (rd_en) begin
      bus_dout_nxt = read_data;
      if (bus_addr == ADDR_COUNT_HI) begin
        count_lo_latch_nxt = count[7:0];
      end
    end

    irq_b_nxt = ~(tf_nxt & ctrl_ie_nxt);
  end

  // State registers; reset drops ack and discards any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en        <= 1'b0;
      ctrl_ie        <= 1'b0;
      ctrl_oneshot   <= 1'b0;
      tf             <= 1'b0;
      prescale       <= RESET_PRESCALE;
      reload         <= RESET_RELOAD;
      count          <= RESET_RELOAD;
      reload_hi_buf  <= 8'h00;
      count_lo_latch <= 8'h00;
      presc_cnt      <= 8'h00;
      bus_dout       <= 8'h00;
      bus_ack        <= 1'b0;
      irq_b          <= 1'b1;
    end else begin
      ctrl_en        <= ctrl_en_nxt;
      ctrl_ie        <= ctrl_ie_nxt;
      ctrl_oneshot   <= ctrl_oneshot_nxt;
      tf             <= tf_nxt;
      prescale       <= prescale_nxt;
      reload         <= reload_nxt;
      count          <= count_nxt;
      reload_hi_buf  <= reload_hi_buf_nxt;
      count_lo_latch <= count_lo_latch_nxt;
      presc_cnt      <= presc_cnt_nxt;
      bus_dout       <= bus_dout_nxt;
      bus_ack        <= bus_cs;
      irq_b          <= irq_b_nxt;
    end
  end

endmodule

// File: tb/tb_m6809_bus_timer.sv
// Directed testbench for m6809_bus_timer. Bus tasks are called on a falling
// edge, present an access for one clock and return on the next falling edge
// with the acknowledged read data.
module tb_m6809_bus_timer;

  logic       clk;
  logic       reset;
  logic       bus_cs;
  logic       bus_rw;
  logic [2:0] bus_addr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_ack;
  logic       irq_b;

  int checks;
  int failures;

  m6809_bus_timer dut (
    .clk      (clk),
    .reset    (reset),
    .bus_cs   (bus_cs),
    .bus_rw   (bus_rw),
    .bus_addr (bus_addr),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .bus_ack  (bus_ack),
    .irq_b    (irq_b)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus_cs   = 1'b1;
    bus_rw   = 1'b0;
    bus_addr = a;
    bus_din  = d;
    @(negedge clk);
    bus_cs = 1'b0;
    bus_rw = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic ack);
    bus_cs   = 1'b1;
    bus_rw   = 1'b1;
    bus_addr = a;
    @(negedge clk);
    bus_cs = 1'b0;
    d      = bus_dout;
    ack    = bus_ack;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    bus_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       ack;
    reset  = 1'b1;
    bus_cs = 1'b0;
    #1;
    checks++;
    if (bus_ack !== 1'b0 || irq_b !== 1'b1 || bus_dout !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ack=%b irq_b=%b dout=%h want 0/1/00", bus_ack, irq_b, bus_dout);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], d, ack);
      checks++;
      if (d !== 8'h00 || ack !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_read_%0d got data=%h ack=%b want 00/1", a, d, ack);
      end
    end
    @(negedge clk);
    checks++;
    if (bus_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_single_cycle got %b want 0", bus_ack);
    end
  endtask

  task automatic test_register_readback();
    logic [7:0] d;
    logic       ack;
    logic [2:0] ra [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [7:0] re [6] = '{8'h07, 8'h5A, 8'h12, 8'h34, 8'h12, 8'h34};
    do_reset();
    bus_write(3'd2, 8'h5A);
    bus_write(3'd3, 8'h12);
    bus_read(3'd3, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reload_hi_buffered got %h want 00", d);
    end
    bus_write(3'd4, 8'h34);
    bus_write(3'd0, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      bus_read(ra[i], d, ack);
      checks++;
      if (d !== re[i] || ack !== 1'b1) begin
        failures++;
        $display("[TB] FAIL readback_addr%0d got data=%h ack=%b want %h/1", ra[i], d, ack, re[i]);
      end
    end
    bus_write(3'd5, 8'hAA);
    bus_write(3'd6, 8'hBB);
    bus_write(3'd7, 8'hCC);
    checks++;
    if (bus_dout !== 8'h34) begin
      failures++;
      $display("[TB] FAIL dout_held_on_write got %h want 34", bus_dout);
    end
    bus_read(3'd5, d, ack);
    checks++;
    if (d !== 8'h12) begin
      failures++;
      $display("[TB] FAIL count_hi_write_ignored got %h want 12", d);
    end
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'h34) begin
      failures++;
      $display("[TB] FAIL count_lo_write_ignored got %h want 34", d);
    end
    bus_read(3'd7, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL addr7_reads_zero got %h want 00", d);
    end
    bus_write(3'd0, 8'h00);
  endtask

  task automatic test_periodic();
    logic [7:0] d;
    logic       ack;
    do_reset();
    bus_write(3'd2, 8'h03);
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h09);
    bus_write(3'd0, 8'h03);
    repeat (39) @(negedge clk);
    checks++;
    if (irq_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL periodic_before_expiry1 irq_b got %b want 1", irq_b);
    end
    @(negedge clk);
    checks++;
    if (irq_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL periodic_expiry1 irq_b got %b want 0", irq_b);
    end
    bus_write(3'd1, 8'h01);
    checks++;
    if (irq_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL status_clear irq_b got %b want 1", irq_b);
    end
    bus_read(3'd5, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL periodic_reload_hi got %h want 00", d);
    end
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'h09) begin
      failures++;
      $display("[TB] FAIL periodic_reload_lo got %h want 09", d);
    end
    repeat (36) @(negedge clk);
    checks++;
    if (irq_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL periodic_before_expiry2 irq_b got %b want 1", irq_b);
    end
    @(negedge clk);
    checks++;
    if (irq_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL periodic_expiry2 irq_b got %b want 0", irq_b);
    end
    bus_write(3'd1, 8'h01);
    repeat (38) @(negedge clk);
    bus_write(3'd1, 8'h01);
    checks++;
    if (irq_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_vs_expiry irq_b got %b want 0", irq_b);
    end
    bus_read(3'd1, d, ack);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("[TB] FAIL clear_vs_expiry_status got %h want 01", d);
    end
    bus_write(3'd0, 8'h00);
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    logic       ack;
    do_reset();
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h04);
    bus_write(3'd0, 8'h05);
    repeat (4) @(negedge clk);
    bus_read(3'd1, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL oneshot_tf_early got %h want 00", d);
    end
    bus_read(3'd1, d, ack);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("[TB] FAIL oneshot_tf_set got %h want 01", d);
    end
    bus_read(3'd0, d, ack);
    checks++;
    if (d !== 8'h04) begin
      failures++;
      $display("[TB] FAIL oneshot_ctrl got %h want 04", d);
    end
    bus_read(3'd5, d, ack);
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL oneshot_count_zero got %h want 00", d);
    end
    checks++;
    if (irq_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oneshot_irq_masked got %b want 1", irq_b);
    end
    bus_write(3'd0, 8'h06);
    checks++;
    if (irq_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ie_enable_irq got %b want 0", irq_b);
    end
    bus_write(3'd1, 8'h00);
    checks++;
    if (irq_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL status_write0_noop got %b want 0", irq_b);
    end
    bus_write(3'd1, 8'h01);
    repeat (100) @(negedge clk);
    bus_read(3'd1, d, ack);
    checks++;
    if (d !== 8'h00 || irq_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oneshot_no_retrigger got status=%h irq_b=%b want 00/1", d, irq_b);
    end
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL oneshot_count_held got %h want 00", d);
    end
  endtask

  task automatic test_atomic_read();
    logic [7:0] d;
    logic       ack;
    do_reset();
    bus_write(3'd3, 8'h01);
    bus_write(3'd4, 8'h00);
    bus_write(3'd0, 8'h01);
    repeat (12) @(negedge clk);
    bus_read(3'd5, d, ack);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL atomic_hi got %h want 00", d);
    end
    repeat (3) @(negedge clk);
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'hF4) begin
      failures++;
      $display("[TB] FAIL atomic_lo got %h want F4", d);
    end
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'hF4) begin
      failures++;
      $display("[TB] FAIL atomic_lo_repeat got %h want F4", d);
    end
    bus_write(3'd0, 8'h00);
    checks++;
    if (bus_dout !== 8'hF4) begin
      failures++;
      $display("[TB] FAIL atomic_dout_held got %h want F4", bus_dout);
    end
    bus_read(3'd5, d, ack);
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'hED) begin
      failures++;
      $display("[TB] FAIL atomic_stopped_count got %h want ED", d);
    end
  endtask

  task automatic test_collisions();
    logic [7:0] d;
    logic       ack;
    do_reset();
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h50);
    bus_write(3'd0, 8'h01);
    repeat (5) @(negedge clk);
    bus_write(3'd4, 8'h20);
    bus_read(3'd5, d, ack);
    bus_read(3'd6, d, ack);
    checks++;
    if (d !== 8'h20) begin
      failures++;
      $display("[TB] FAIL commit_vs_tick got %h want 20", d);
    end
    bus_write(3'd0, 8'h05);
    bus_write(3'd4, 8'h02);
    repeat (2) @(negedge clk);
    bus_write(3'd0, 8'h05);
    bus_read(3'd0, d, ack);
    checks++;
    if (d !== 8'h05) begin
      failures++;
      $display("[TB] FAIL ctrl_write_vs_autoclear got %h want 05", d);
    end
    bus_read(3'd1, d, ack);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("[TB] FAIL collision_tf got %h want 01", d);
    end
    bus_read(3'd0, d, ack);
    checks++;
    if (d !== 8'h04) begin
      failures++;
      $display("[TB] FAIL autoclear_after got %h want 04", d);
    end
  endtask

  task automatic test_reset_mid_access();
    bus_cs   = 1'b1;
    bus_rw   = 1'b1;
    bus_addr = 3'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_access_ack got %b want 1", bus_ack);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_drops_ack got %b want 0", bus_ack);
    end
    bus_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus_ack !== 1'b0) begin
        failures++;
        $display("[TB] FAIL no_ack_after_reset_%0d got %b want 0", i, bus_ack);
      end
    end
  endtask

  // Test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus_cs   = 1'b0;
    bus_rw   = 1'b1;
    bus_addr = 3'd0;
    bus_din  = 8'h00;
    @(negedge clk);
    test_reset();
    test_register_readback();
    test_periodic();
    test_oneshot();
    test_atomic_read();
    test_collisions();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
